// File: rtl/fft_input_reorder.sv
// Frame buffer and bit-reversal reorder ahead of the first butterfly4 stage of a 32-point DIT FFT.
// Define FFT_REORDER_PINGPONG_EN for two banks so one frame loads while the previous one emits.
module fft_input_reorder #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_r,
   input  logic [N-1:0] in_i,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out0_r,
   output logic [N-1:0] out0_i,
   output logic [N-1:0] out1_r,
   output logic [N-1:0] out1_i,
   output logic [N-1:0] out2_r,
   output logic [N-1:0] out2_i,
   output logic [N-1:0] out3_r,
   output logic [N-1:0] out3_i,
   output logic         out_first,
   output logic         out_last
);

`ifdef FFT_REORDER_PINGPONG_EN
   localparam int NB = 2;
   localparam int AW = 6;
`else
   localparam int NB = 1;
   localparam int AW = 5;
`endif

   // Handshakes: a transfer happens on a rising clk edge when valid && ready;
   // valid never depends combinationally on ready, and in_ready only on registered state.

   logic [4:0]    wr_cnt_q, wr_cnt_d;
   logic [2:0]    grp_q, grp_d;
   logic [NB-1:0] full_q, full_d;
`ifdef FFT_REORDER_PINGPONG_EN
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
`endif

   logic [N-1:0]  mem_r_q [NB*32];
   logic [N-1:0]  mem_i_q [NB*32];

   logic          wr_full, rd_full, wr_en, rd_en;
   logic [AW-1:0] wr_addr;
   logic [4:0]    lane_idx [4];
   logic [AW-1:0] rd_addr [4];

   function automatic logic [4:0] rev5(input logic [4:0] a);
      return {a[0], a[1], a[2], a[3], a[4]};
   endfunction

   always_comb begin
`ifdef FFT_REORDER_PINGPONG_EN
      wr_full = full_q[wr_bank_q];
      rd_full = full_q[rd_bank_q];
`else
      wr_full = full_q[0];
      rd_full = full_q[0];
`endif
      in_ready  = !wr_full;
      out_valid = rd_full;
      wr_en     = in_valid && !wr_full;
      rd_en     = rd_full && out_ready;

      wr_cnt_d = wr_cnt_q;
      grp_d    = grp_q;
      full_d   = full_q;
`ifdef FFT_REORDER_PINGPONG_EN
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wr_addr   = {wr_bank_q, wr_cnt_q};
`else
      wr_addr   = wr_cnt_q;
`endif

      if (wr_en) begin
         wr_cnt_d = wr_cnt_q + 5'd1;
         if (wr_cnt_q == 5'd31) begin
`ifdef FFT_REORDER_PINGPONG_EN
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
`else
            full_d[0] = 1'b1;
`endif
         end
      end

      // The read bank is always full and the write bank never, so these never collide.
      if (rd_en) begin
         grp_d = grp_q + 3'd1;
         if (grp_q == 3'd7) begin
`ifdef FFT_REORDER_PINGPONG_EN
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
`else
            full_d[0] = 1'b0;
`endif
         end
      end
   end

   // Lane k holds sample rev5(4*grp + j) with j = 0,2,1,3, pairing (out0,out2) and (out1,out3).
   always_comb begin
      lane_idx[0] = rev5({grp_q, 2'd0});
      lane_idx[1] = rev5({grp_q, 2'd2});
      lane_idx[2] = rev5({grp_q, 2'd1});
      lane_idx[3] = rev5({grp_q, 2'd3});
      for (int k = 0; k < 4; k++) begin
`ifdef FFT_REORDER_PINGPONG_EN
         rd_addr[k] = {rd_bank_q, lane_idx[k]};
`else
         rd_addr[k] = lane_idx[k];
`endif
      end
      out0_r    = mem_r_q[rd_addr[0]];
      out0_i    = mem_i_q[rd_addr[0]];
      out1_r    = mem_r_q[rd_addr[1]];
      out1_i    = mem_i_q[rd_addr[1]];
      out2_r    = mem_r_q[rd_addr[2]];
      out2_i    = mem_i_q[rd_addr[2]];
      out3_r    = mem_r_q[rd_addr[3]];
      out3_i    = mem_i_q[rd_addr[3]];
      out_first = rd_full && (grp_q == 3'd0);
      out_last  = rd_full && (grp_q == 3'd7);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_cnt_q <= '0;
         grp_q    <= '0;
         full_q   <= '0;
`ifdef FFT_REORDER_PINGPONG_EN
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
`endif
      end else begin
         wr_cnt_q <= wr_cnt_d;
         grp_q    <= grp_d;
         full_q   <= full_d;
`ifdef FFT_REORDER_PINGPONG_EN
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NB*32; i++) begin
            mem_r_q[i] <= '0;
            mem_i_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_r_q[wr_addr] <= in_r;
         mem_i_q[wr_addr] <= in_i;
      end
   end

endmodule

// File: tb/tb_fft_input_reorder.sv
// Self-checking bench for fft_input_reorder: directed ordering/backpressure/reset cases plus
// randomized traffic scored against a frame-level bit-reversal model.
module tb_fft_input_reorder;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] in_r = '0;
   logic [N-1:0] in_i = '0;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out0_r, out0_i, out1_r, out1_i, out2_r, out2_i, out3_r, out3_i;
   logic         out_first, out_last;

   int  n_checks = 0;
   int  n_fail = 0;
   int  rdy_mode = 0;
   bit  rdy_manual = 1'b0;
   bit  rnd_bit = 1'b0;
   bit  gap_mon = 1'b0;
   bit  prev_ready = 1'b1;
   int  low_cnt = 0;
   int  low_runs = 0;
   int  xfer_cnt = 0;

   logic [15:0] in_q[$];
   logic [65:0] exp_q[$];

   assign out_ready = (rdy_mode == 1) ? rnd_bit : rdy_manual;

   fft_input_reorder #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .out0_r(out0_r), .out0_i(out0_i), .out1_r(out1_r), .out1_i(out1_i),
      .out2_r(out2_r), .out2_i(out2_i), .out3_r(out3_r), .out3_i(out3_i),
      .out_first(out_first), .out_last(out_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1 rnd_bit = 1'($urandom_range(0, 1));
   end

   task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int rev(input int a);
      int r = 0;
      for (int b = 0; b < 5; b++)
         if ((a >> b) & 1) r += 1 << (4 - b);
      return r;
   endfunction

   // Reference: once 32 samples are in, emit 8 groups of lanes x[rev(4g)], x[rev(4g+2)], x[rev(4g+1)], x[rev(4g+3)].
   task automatic build_frame();
      logic [15:0] f[32];
      logic fst, lst;
      for (int i = 0; i < 32; i++) f[i] = in_q[i];
      in_q.delete();
      for (int g = 0; g < 8; g++) begin
         fst = (g == 0);
         lst = (g == 7);
         exp_q.push_back({fst, lst, f[rev(4*g)], f[rev(4*g+2)], f[rev(4*g+1)], f[rev(4*g+3)]});
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         in_q.delete();
         exp_q.delete();
      end else begin
         if (in_valid && in_ready) begin
            in_q.push_back({in_r, in_i});
            if (in_q.size() == 32) build_frame();
         end
         if (out_valid) begin
            if (exp_q.size() == 0) check("sb_unexpected_group", 66'(1), 66'(0));
            else begin
               check("sb_group", {out_first, out_last, out0_r, out0_i, out1_r, out1_i,
                                  out2_r, out2_i, out3_r, out3_i}, exp_q[0]);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  xfer_cnt++;
               end
            end
         end else check("idle_flags", 66'({out_first, out_last}), 66'(0));
         if (gap_mon) begin
            if (!in_ready) begin
               low_cnt++;
               if (prev_ready) low_runs++;
            end
            prev_ready = in_ready;
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"}, 66'(in_ready), 66'(1));
      check({tag, "_out_valid"}, 66'(out_valid), 66'(0));
      check({tag, "_flags"}, 66'({out_first, out_last}), 66'(0));
      check({tag, "_lanes"}, 66'({out0_r, out0_i, out1_r, out1_i, out2_r, out2_i, out3_r, out3_i}), 66'(0));
   endtask

   // Lanes expected to carry real a_k and imaginary -a_k.
   task automatic check_lanes(input string tag, input int a0, input int a1, input int a2, input int a3);
      logic [7:0] e0, e1, e2, e3;
      e0 = 8'(a0); e1 = 8'(a1); e2 = 8'(a2); e3 = 8'(a3);
      check({tag, "_re"}, 66'({out0_r, out1_r, out2_r, out3_r}), 66'({e0, e1, e2, e3}));
      check({tag, "_im"}, 66'({out0_i, out1_i, out2_i, out3_i}), 66'({-e0, -e1, -e2, -e3}));
   endtask

   // vmode: 0 continuous valid, 1 valid on alternate cycles, 2 random valid. Called at posedge+1.
   task automatic feed(input int base, input int count, input int vmode, input bit rdata);
      int n = 0;
      int cyc = 0;
      bit acc;
      logic [7:0] dr, di;
      dr = rdata ? 8'($urandom) : 8'(base);
      di = rdata ? 8'($urandom) : 8'(-base);
      while (n < count && cyc < 3000) begin
         case (vmode)
            0: in_valid = 1'b1;
            1: in_valid = (cyc % 2 == 0);
            default: in_valid = 1'($urandom_range(0, 1));
         endcase
         in_r = dr;
         in_i = di;
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         cyc++;
         if (acc) begin
            n++;
            dr = rdata ? 8'($urandom) : 8'(base + n);
            di = rdata ? 8'($urandom) : 8'(-(base + n));
         end
      end
      in_valid = 1'b0;
      if (n < count) check("feed_timeout", 66'(n), 66'(count));
   endtask

   task automatic step_group();
      rdy_manual = 1'b1;
      @(posedge clk); #1;
      rdy_manual = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic drain(input int limit);
      int c = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || out_valid) && c < limit) begin
         @(negedge clk);
         c++;
      end
      if (c >= limit) check("drain_timeout", 66'(exp_q.size()), 66'(0));
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_low, exp_runs;
      #1;
      check_reset_vals("por");
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Ordering and backpressure on x[n] = n, -n.
      rdy_mode = 0;
      rdy_manual = 1'b0;
      check("pre_valid", 66'(out_valid), 66'(0));
      feed(0, 32, 0, 1'b0);
      @(negedge clk);
      check("latency_valid", 66'(out_valid), 66'(1));
      check("no_ready_when_full", 66'(in_ready), 66'(0));
      check_lanes("grp0", 0, 8, 16, 24);
      check("grp0_flags", 66'({out_first, out_last}), 66'(2'b10));
      @(posedge clk); #1;
      step_group();
      @(negedge clk);
      check_lanes("grp1", 4, 12, 20, 28);
      check("grp1_flags", 66'({out_first, out_last}), 66'(2'b00));
      @(posedge clk); #1;
      step_group();
      step_group();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_lanes("stall_grp3", 6, 14, 22, 30);
         check("stall_valid", 66'(out_valid), 66'(1));
         @(posedge clk); #1;
      end
      for (int i = 0; i < 4; i++) step_group();
      @(negedge clk);
      check_lanes("grp7", 7, 15, 23, 31);
      check("grp7_flags", 66'({out_first, out_last}), 66'(2'b01));
      @(posedge clk); #1;
      step_group();
      @(negedge clk);
      check("after_frame_valid", 66'(out_valid), 66'(0));
      check("after_frame_ready", 66'(in_ready), 66'(1));
      @(posedge clk); #1;

      // Input stall: valid on alternate cycles.
      rdy_manual = 1'b1;
      feed(0, 32, 1, 1'b0);
      drain(200);

      // Throughput: three back-to-back frames with continuous valid and ready.
`ifdef FFT_REORDER_PINGPONG_EN
      exp_low = 0;
      exp_runs = 0;
`else
      exp_low = 24;
      exp_runs = 3;
`endif
      low_cnt = 0;
      low_runs = 0;
      xfer_cnt = 0;
      prev_ready = 1'b1;
      gap_mon = 1'b1;
      feed(0, 96, 0, 1'b1);
      drain(200);
      repeat (3) begin @(posedge clk); #1; end
      gap_mon = 1'b0;
      check("tput_ready_low_cycles", 66'(low_cnt), 66'(exp_low));
      check("tput_ready_low_runs", 66'(low_runs), 66'(exp_runs));
      check("tput_groups", 66'(xfer_cnt), 66'(24));

      // Random valid, random ready, random data.
      rdy_mode = 1;
      feed(0, 128, 2, 1'b1);
      drain(500);
      rdy_mode = 0;
      rdy_manual = 1'b0;

      // Reset with a full frame pending.
      feed(0, 32, 0, 1'b1);
      rst = 1'b0;
      #1;
      check_reset_vals("rst_pending");
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Reset after 17 samples of a partial frame, then a fresh frame y[n] = 100 + n.
      feed(0, 17, 0, 1'b1);
      rst = 1'b0;
      #1;
      check_reset_vals("rst_partial");
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      feed(100, 32, 0, 1'b0);
      @(negedge clk);
      check("fresh_valid", 66'(out_valid), 66'(1));
      check_lanes("fresh_grp0", 100, 108, 116, 124);
      @(posedge clk); #1;
      rdy_manual = 1'b1;
      drain(200);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
